// File: rtl/bit_fill_deserializer_if.sv
// Handshake bundle for the bit-fill deserializer.
// The serial input side, the word output side and the fill counter travel together.
// master: the testbench or upstream/downstream logic that drives the stage.
// slave: the deserializer itself.
interface bit_fill_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_partial;
  logic             out_all_ones;
  logic             out_all_zeros;
  logic [CW-1:0]    fill_count;

  modport master (
    output in_valid, in_bit, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_partial,
           out_all_ones, out_all_zeros, fill_count
  );

  modport slave (
    input  in_valid, in_bit, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_partial,
           out_all_ones, out_all_zeros, fill_count
  );
endinterface

// File: rtl/bit_fill_deserializer.sv
// Serial-to-parallel stage that builds a WIDTH-bit word one bit per accepted beat.
// A flush closes a partial word early and pads the unfilled positions with PAD_BIT.
// The finished word and its all-ones/all-zeros flags are registered together.
module bit_fill_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PAD_BIT   = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_fill_deserializer_if.slave bus
);
  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);
  localparam logic [0:0]    FILL       = 1'b0;
  localparam logic [0:0]    HOLD       = 1'b1;

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_nxt_s;
  logic [WIDTH-1:0] final_word_s;
  logic [CW-1:0]    fill_r;
  logic [CW-1:0]    count_after_s;
  logic [CW-1:0]    fill_nxt_s;
  logic [WIDTH-1:0] out_data_r;
  logic             out_partial_r;
  logic             out_all_ones_r;
  logic             out_all_zeros_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             full_s;
  logic             flush_s;
  logic             complete_s;

  // Fill order: position i receives the bit accepted at this fill index.
  function automatic int fill_index(input int i);
    return LSB_FIRST ? i : (WIDTH - 1 - i);
  endfunction

  // Accept, completion and flush decisions plus next-word assembly.
  always_comb begin
    in_ready_s    = (state_r == FILL) || bus.out_ready;
    accept_s      = bus.in_valid && in_ready_s;
    count_after_s = accept_s ? (fill_r + {{(CW-1){1'b0}}, 1'b1}) : fill_r;
    full_s        = accept_s && (count_after_s == FULL_COUNT);
    // A flush on the completing beat is treated as an ordinary full word.
    flush_s       = in_ready_s && bus.in_flush &&
                    (count_after_s != {CW{1'b0}}) && !full_s;
    complete_s    = full_s || flush_s;
    word_nxt_s    = word_r;
    final_word_s  = word_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept_s && (fill_index(i) == int'(fill_r))) begin
        word_nxt_s[i] = bus.in_bit;
      end else begin
        word_nxt_s[i] = word_r[i];
      end
    end
    // Positions not yet reached by the fill take the pad value.
    for (int i = 0; i < WIDTH; i++) begin
      if (fill_index(i) < int'(count_after_s)) begin
        final_word_s[i] = word_nxt_s[i];
      end else begin
        final_word_s[i] = PAD_BIT;
      end
    end
    if (complete_s) begin
      fill_nxt_s = {CW{1'b0}};
    end else begin
      fill_nxt_s = count_after_s;
    end
    case (state_r)
      FILL: begin
        if (complete_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FILL;
        end
      end
      HOLD: begin
        if (complete_s) begin
          state_nxt_s = HOLD;
        end else if (bus.out_ready) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // FSM state, word under construction and fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      word_r  <= {WIDTH{1'b0}};
      fill_r  <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      word_r  <= word_nxt_s;
      fill_r  <= fill_nxt_s;
    end
  end

  // Presented word and its flags, captured only when a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r      <= {WIDTH{1'b0}};
      out_partial_r   <= 1'b0;
      out_all_ones_r  <= 1'b0;
      out_all_zeros_r <= 1'b1;
    end else if (complete_s) begin
      out_data_r      <= final_word_s;
      out_partial_r   <= flush_s;
      out_all_ones_r  <= &final_word_s;
      out_all_zeros_r <= ~|final_word_s;
    end
  end

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = (state_r == HOLD);
  assign bus.out_data      = out_data_r;
  assign bus.out_partial   = out_partial_r;
  assign bus.out_all_ones  = out_all_ones_r;
  assign bus.out_all_zeros = out_all_zeros_r;
  assign bus.fill_count    = fill_r;
endmodule

// File: tb/tb_bit_fill_deserializer.sv
// Directed testbench for bit_fill_deserializer.
// Three instances share one stimulus: a = LSB-first/pad 0, b = MSB-first/pad 0,
// c = LSB-first/pad 1.
module tb_bit_fill_deserializer;
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic in_bit    = 1'b0;
  logic in_flush  = 1'b0;
  logic out_ready = 1'b0;
  int   n_assert  = 0;
  int   n_fail    = 0;
  logic [31:0] pat;

  bit_fill_deserializer_if #(.WIDTH(8)) ia ();
  bit_fill_deserializer_if #(.WIDTH(8)) ib ();
  bit_fill_deserializer_if #(.WIDTH(8)) ic ();

  assign ia.in_valid  = in_valid;
  assign ia.in_bit    = in_bit;
  assign ia.in_flush  = in_flush;
  assign ia.out_ready = out_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_bit    = in_bit;
  assign ib.in_flush  = in_flush;
  assign ib.out_ready = out_ready;
  assign ic.in_valid  = in_valid;
  assign ic.in_bit    = in_bit;
  assign ic.in_flush  = in_flush;
  assign ic.out_ready = out_ready;

  bit_fill_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1), .PAD_BIT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave));
  bit_fill_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0), .PAD_BIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave));
  bit_fill_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1), .PAD_BIT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ic.slave));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic f, input logic r);
    in_valid  = v;
    in_bit    = b;
    in_flush  = f;
    out_ready = r;
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[7-i] = x[i];
    return y;
  endfunction

  // Stream 8 bits (bits[0] first) with out_ready=1, checking fill progress and result.
  task automatic send8(input string tag, input logic [7:0] bits);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, bits[i], 1'b0, 1'b1);
      tick();
      if (i == 0) begin
        chk({tag, "_first_valid"}, ia.out_valid, 1'b0);
        chk({tag, "_first_fill"}, ia.fill_count, 4'd1);
      end
      if (i == 6) chk({tag, "_fill7"}, ia.fill_count, 4'd7);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_valid"}, ia.out_valid, 1'b1);
    chk({tag, "_data_a"}, ia.out_data, bits);
    chk({tag, "_data_b"}, ib.out_data, rev8(bits));
    chk({tag, "_partial"}, ia.out_partial, 1'b0);
    chk({tag, "_fill0"}, ia.fill_count, 4'd0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_valid", ia.out_valid, 1'b0);
    chk("rst_data", ia.out_data, 8'h00);
    chk("rst_partial", ia.out_partial, 1'b0);
    chk("rst_ones", ia.out_all_ones, 1'b0);
    chk("rst_zeros", ia.out_all_zeros, 1'b1);
    chk("rst_fill", ia.fill_count, 4'd0);
    chk("rst_in_ready", ia.in_ready, 1'b1);
    rst_n = 1'b1;

    // Stream 1,0,1,1,0,0,1,0: LSB-first 0x4D, MSB-first 0xB2
    send8("w4d", 8'h4D);
    chk("w4d_b", ib.out_data, 8'hB2);
    chk("w4d_c", ic.out_data, 8'h4D);
    chk("w4d_ones", ia.out_all_ones, 1'b0);
    chk("w4d_zeros", ia.out_all_zeros, 1'b0);

    // All ones and all zeros words
    send8("wff", 8'hFF);
    chk("wff_ones_a", ia.out_all_ones, 1'b1);
    chk("wff_ones_b", ib.out_all_ones, 1'b1);
    chk("wff_zeros", ia.out_all_zeros, 1'b0);
    send8("w00", 8'h00);
    chk("w00_zeros_a", ia.out_all_zeros, 1'b1);
    chk("w00_zeros_b", ib.out_all_zeros, 1'b1);
    chk("w00_ones", ia.out_all_ones, 1'b0);

    // Stall: word held 5 cycles with in_valid=1
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_in_ready0", ia.in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", ia.out_valid, 1'b1);
      chk("stall_data", ia.out_data, 8'h00);
      chk("stall_zeros", ia.out_all_zeros, 1'b1);
      chk("stall_fill", ia.fill_count, 4'd0);
      chk("stall_in_ready", ia.in_ready, 1'b0);
    end
    // Release with bit 1: taken immediately into bit 0
    send8("w01", 8'h01);

    // Flush after 1,1,0
    drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    chk("fl_consumed", ia.out_valid, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1); tick();
    chk("fl_fill3", ia.fill_count, 4'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("fl_valid", ia.out_valid, 1'b1);
    chk("fl_data_c", ic.out_data, 8'hFB);
    chk("fl_partial_c", ic.out_partial, 1'b1);
    chk("fl_ones_c", ic.out_all_ones, 1'b0);
    chk("fl_zeros_c", ic.out_all_zeros, 1'b0);
    chk("fl_data_a", ia.out_data, 8'h03);
    chk("fl_partial_a", ia.out_partial, 1'b1);
    chk("fl_data_b", ib.out_data, 8'hC0);
    chk("fl_fill0", ia.fill_count, 4'd0);
    // Flush with nothing collected: no word
    tick();
    chk("fl_empty_valid1", ia.out_valid, 1'b0);
    tick();
    chk("fl_empty_valid2", ia.out_valid, 1'b0);
    chk("fl_empty_fill", ia.fill_count, 4'd0);

    // Flush on the completing beat: ordinary full word
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1); tick();
    chk("flfull_valid", ia.out_valid, 1'b1);
    chk("flfull_data", ia.out_data, 8'hFF);
    chk("flfull_partial", ia.out_partial, 1'b0);

    // Flush together with the first bit of a word
    drive(1'b1, 1'b1, 1'b1, 1'b1); tick();
    chk("fl1_valid", ia.out_valid, 1'b1);
    chk("fl1_data_a", ia.out_data, 8'h01);
    chk("fl1_partial_a", ia.out_partial, 1'b1);
    chk("fl1_data_b", ib.out_data, 8'h80);
    chk("fl1_data_c", ic.out_data, 8'hFF);
    chk("fl1_ones_c", ic.out_all_ones, 1'b1);

    // Back-to-back 32 bits, 4 words
    pat = 32'hC3A5_96E1;
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, pat[k], 1'b0, 1'b1);
      tick();
      chk("b2b_valid", ia.out_valid, ((k % 8) == 7) ? 1'b1 : 1'b0);
      if ((k % 8) == 7) begin
        chk("b2b_data_a", ia.out_data, pat[k-7 +: 8]);
        chk("b2b_data_b", ib.out_data, rev8(pat[k-7 +: 8]));
      end
    end

    // Reset mid-word
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    end
    chk("rmid_fill5", ia.fill_count, 4'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_valid", ia.out_valid, 1'b0);
    chk("rmid_fill", ia.fill_count, 4'd0);
    chk("rmid_data", ia.out_data, 8'h00);
    chk("rmid_zeros", ia.out_all_zeros, 1'b1);
    #1 rst_n = 1'b1;
    send8("rmid_w", 8'h4D);

    // Reset during HOLD
    drive(1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("rhold_valid_pre", ia.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rhold_valid", ia.out_valid, 1'b0);
    chk("rhold_data", ia.out_data, 8'h00);
    chk("rhold_fill", ia.fill_count, 4'd0);
    chk("rhold_ones", ia.out_all_ones, 1'b0);
    chk("rhold_zeros", ia.out_all_zeros, 1'b1);
    #1 rst_n = 1'b1;
    send8("rhold_w", 8'h96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_fill_deserializer.md
Name: bit_fill_deserializer

Overview:
- Serial-to-parallel stage that assembles a WIDTH-bit word one bit per accepted beat, writing bit positions by index.
- Feeds the per-bit-indexed vector consumers and checkers downstream with a registered word plus all-ones/all-zeros flags.
- Valid/ready on both sides; a flush input closes a partial word early by padding the unfilled positions.

Parameters:
- WIDTH, 8, output word width in bits; legal range 2..64.
- LSB_FIRST, 1, 1: first accepted bit lands in bit 0 and fill ascends; 0: first bit lands in bit WIDTH-1 and fill descends.
- PAD_BIT, 1'b0, value written into unfilled positions on flush.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_bit is valid.
- in_ready, output, 1: stage can accept a bit this cycle.
- in_bit, input, 1: serial data bit.
- in_flush, input, 1: close the current partial word; sampled only when in_ready=1.
- out_valid, output, 1: out_data holds a complete word.
- out_ready, input, 1: downstream accepts the word.
- out_data, output, WIDTH: assembled word.
- out_partial, output, 1: the word was closed by flush; at least one position is PAD_BIT.
- out_all_ones, output, 1: out_data == all ones.
- out_all_zeros, output, 1: out_data == all zeros.
- fill_count, output, $clog2(WIDTH+1): bits accepted into the word currently being built.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=0, out_partial=0, out_all_ones=0, out_all_zeros=1, fill_count=0, state=FILL.
- States:
  - FILL: collecting bits.
  - HOLD: word presented, waiting for out_ready.
- in_ready = !out_valid || out_ready, combinational. A bit is accepted when in_valid && in_ready.
- Write position: pos = LSB_FIRST ? fill_count : WIDTH-1-fill_count. An accepted bit writes the internal word[pos] and increments fill_count.
- Completion: when the accepted bit makes fill_count reach WIDTH:
  - the word, its flags and out_partial=0 are registered into out_data on that edge;
  - out_valid=1 from the next cycle;
  - fill_count returns to 0;
  - state goes to HOLD.
- Latency: the last bit accepted in cycle N gives out_valid=1 in cycle N+1.
- HOLD with out_ready=0:
  - out_data, out_partial and both flags stay stable;
  - in_ready=0; inputs are ignored.
- HOLD with out_ready=1:
  - out_valid clears next cycle unless a new word completes in the same cycle.
  - A bit accepted in the same cycle is written to the first position of the new word, with fill_count 0→1. There is no bubble.
- Flush: when in_ready=1, in_flush=1 and fill_count>0 (after counting any bit accepted in the same cycle):
  - all remaining positions are set to PAD_BIT;
  - the word completes as above with out_partial=1.
- Flush with fill_count==0 and no bit accepted in that cycle: no effect and no empty word is produced.
- Flush in the same cycle as the bit that completes a full word: out_partial=0.
- Flags are computed from the final word, including padding, and are registered with out_data. They are never computed combinationally from out_data.
- Reset asserted mid-word or during HOLD: the partial word and the held word are both discarded; all outputs return to their reset values immediately.
- The internal word is not cleared between words. Every position is overwritten, by a bit or by padding, before presentation.

Test Plan:
- WIDTH=8, LSB_FIRST=1, out_ready=1; stream bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'h4D one cycle after the 8th bit; out_partial=0; out_all_ones=0; out_all_zeros=0.
- LSB_FIRST=0, same stream -> out_data=8'hB2; eight 1s -> 8'hFF with out_all_ones=1; eight 0s -> out_all_zeros=1.
- Complete a word with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and out_data stable throughout. Raise out_ready with in_bit=1 -> next word has fill_count=1 and bit0=1, no cycle lost.
- PAD_BIT=1; send 1,1,0 then in_flush -> out_data=8'hFB, out_partial=1, fill_count=0 afterwards. A flush with fill_count=0 -> no out_valid.
- Back-to-back: 32 random bits with out_ready always 1 -> 4 words with contiguous out_valid pulses spaced 8 cycles apart, each matching the reference packing.
- Assert rst_n low after 5 bits, and again during HOLD -> out_valid=0, fill_count=0 and out_data=0 asynchronously. The next 8 bits form a clean word.
